async_frame_receiver: RTL and testbench

ASYNC_FRAME_RECEIVER -- requirements
Module: async_frame_receiver

---
 rtl/async_frame_receiver_if.sv | 18 +
 rtl/async_frame_receiver.sv | 109 ++++++++++
 tb/tb_async_frame_receiver.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/async_frame_receiver_if.sv
// async_frame_receiver_if: lane, strobe and frame inputs plus the committed-message outputs of the frame receiver
// master drives din/strobe/frame and observes the results; slave is the receiver side
interface async_frame_receiver_if #(
  parameter int LANE_W = 6,
  parameter int MSG_BITS = 100
);
  localparam int NBEATS = (MSG_BITS + LANE_W - 1) / LANE_W;
  localparam int CW = $clog2(NBEATS + 1);
  logic [LANE_W-1:0] din;
  logic strobe;
  logic frame;
  logic [MSG_BITS-1:0] msg;
  logic msg_valid;
  logic frame_err;
  logic [CW-1:0] beat_cnt;
  modport master(output din, strobe, frame, input msg, msg_valid, frame_err, beat_cnt);
  modport slave(input din, strobe, frame, output msg, msg_valid, frame_err, beat_cnt);
endinterface

// File: rtl/async_frame_receiver.sv
// async_frame_receiver: synchronizes and glitch-filters an async lane/strobe/frame bus and assembles framed beats into messages
// clk, rst_n (async active-low); bus.din/strobe/frame async in; bus.msg/msg_valid/frame_err/beat_cnt out
module async_frame_receiver #(
  parameter int LANE_W = 6,
  parameter int MSG_BITS = 100,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC = 4
) (
  input logic clk,
  input logic rst_n,
  async_frame_receiver_if.slave bus
);
  localparam int NBEATS = (MSG_BITS + LANE_W - 1) / LANE_W;
  localparam int CW = $clog2(NBEATS + 1);
  localparam int W = LANE_W + 2;
  localparam logic [CW-1:0] NB = CW'(NBEATS);
  localparam logic [7:0] FLAST = 8'(FILT_CYC - 1);
  typedef enum logic [1:0] {IDLE, RECV, OVFL} state_t;
  state_t state_q, state_d;
  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] filt_q, filt_d;
  logic [7:0] fcnt_q [W];
  logic [7:0] fcnt_d [W];
  logic s_prev_q, f_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic valid_q, valid_d;
  logic [MSG_BITS-1:0] asm_q, asm_d, msg_q, msg_d;
  logic [LANE_W-1:0] din_f;
  logic s_f, f_f, s_rise, f_rise, f_fall;
  assign din_f = filt_q[LANE_W-1:0];
  assign s_f = filt_q[LANE_W];
  assign f_f = filt_q[LANE_W+1];
  assign s_rise = s_f & ~s_prev_q;
  assign f_rise = f_f & ~f_prev_q;
  assign f_fall = ~f_f & f_prev_q;
  // per-bit filter: flip only after FILT_CYC consecutive cycles of disagreement
  always_comb begin
    filt_d = filt_q;
    for (int b = 0; b < W; b++) begin
      fcnt_d[b] = '0;
      if (sync_q[SYNC_STAGES-1][b] != filt_q[b]) begin
        fcnt_d[b] = (fcnt_q[b] == FLAST) ? 8'd0 : fcnt_q[b] + 8'd1;
        filt_d[b] = (fcnt_q[b] == FLAST) ? ~filt_q[b] : filt_q[b];
      end
    end
  end
  // f_rise restarts a frame from any state; f_fall takes priority over a coincident strobe
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    asm_d = asm_q;
    msg_d = msg_q;
    valid_d = 1'b0;
    if (f_rise) begin
      state_d = RECV;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (f_fall && state_q != IDLE) begin
      state_d = IDLE;
      if (state_q == RECV && cnt_q == NB) begin
        msg_d = asm_q;
        valid_d = 1'b1;
      end else err_d = 1'b1;
    end else if (s_rise && state_q == RECV) begin
      if (cnt_q == NB) begin
        state_d = OVFL;
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < MSG_BITS; i++)
          if (i / LANE_W == int'(cnt_q)) asm_d[i] = din_f[i % LANE_W];
        cnt_d = cnt_q + CW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int b = 0; b < W; b++) fcnt_q[b] <= '0;
      filt_q <= '0;
      s_prev_q <= 1'b0;
      f_prev_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
      asm_q <= '0;
      msg_q <= '0;
    end else begin
      sync_q[0] <= {bus.frame, bus.strobe, bus.din};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int b = 0; b < W; b++) fcnt_q[b] <= fcnt_d[b];
      filt_q <= filt_d;
      s_prev_q <= s_f;
      f_prev_q <= f_f;
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      valid_q <= valid_d;
      asm_q <= asm_d;
      msg_q <= msg_d;
    end
  end
  assign bus.msg = msg_q;
  assign bus.msg_valid = valid_q;
  assign bus.frame_err = err_q;
  assign bus.beat_cnt = cnt_q;
endmodule

// File: tb/tb_async_frame_receiver.sv
// tb_async_frame_receiver: directed frames with a message scoreboard checked by an independent msg_valid monitor
module tb_async_frame_receiver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [99:0] exp_q [$];
  logic [99:0] held;
  async_frame_receiver_if #(.LANE_W(6), .MSG_BITS(100)) bus ();
  async_frame_receiver #(.LANE_W(6), .MSG_BITS(100), .SYNC_STAGES(2), .FILT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [5:0] dat(input int mode, input int i);
    return (mode == 0) ? 6'(i) : 6'((i * 5 + 3) & 63);
  endfunction
  function automatic logic [99:0] build(input int mode);
    logic [101:0] e;
    e = '0;
    for (int i = 0; i < 17; i++) e[i*6 +: 6] = dat(mode, i);
    return e[99:0];
  endfunction
  task automatic beat(input logic [5:0] d);
    bus.din = d;
    tick(8);
    bus.strobe = 1'b1;
    tick(8);
    bus.strobe = 1'b0;
    tick(8);
  endtask
  task automatic beats(input int mode, input int n);
    for (int i = 0; i < n; i++) beat(dat(mode, i));
  endtask
  task automatic open_frame;
    bus.frame = 1'b1;
    tick(12);
  endtask
  task automatic close_frame;
    bus.frame = 1'b0;
    tick(12);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (bus.msg_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_msg_valid: got msg %0h expected no commit", bus.msg);
        end else begin
          logic [99:0] e;
          e = exp_q.pop_front();
          if (bus.msg !== e) begin
            errors++;
            $display("FAIL commit_msg: got %0h expected %0h", bus.msg, e);
          end
        end
      end
    end
  end
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.din = '0;
    bus.strobe = 1'b0;
    bus.frame = 1'b0;
    tick(3);
    chk("reset_msg", 128'(bus.msg), 0);
    chk("reset_flags", 128'({bus.msg_valid, bus.frame_err, bus.beat_cnt}), 0);
    rst_n = 1'b1;
    tick(3);
    // full frame, din = beat index
    open_frame;
    chk("open_cnt", 128'(bus.beat_cnt), 0);
    beats(0, 17);
    chk("full_cnt", 128'(bus.beat_cnt), 17);
    exp_q.push_back(build(0));
    close_frame;
    chk("full_lane0", 128'(bus.msg[5:0]), 0);
    chk("full_lane1", 128'(bus.msg[11:6]), 1);
    chk("full_lane15", 128'(bus.msg[95:90]), 15);
    chk("full_top", 128'(bus.msg[99:96]), 0);
    chk("full_err", 128'(bus.frame_err), 0);
    held = build(0);
    // short frame
    open_frame;
    beats(1, 16);
    close_frame;
    chk("short_err", 128'(bus.frame_err), 1);
    chk("short_msg_held", 128'(bus.msg), 128'(held));
    open_frame;
    chk("reopen_err", 128'(bus.frame_err), 0);
    chk("reopen_cnt", 128'(bus.beat_cnt), 0);
    // overflow
    beats(0, 18);
    chk("ovfl_cnt", 128'(bus.beat_cnt), 17);
    chk("ovfl_err", 128'(bus.frame_err), 1);
    close_frame;
    chk("ovfl_msg_held", 128'(bus.msg), 128'(held));
    // strobe glitches
    open_frame;
    bus.strobe = 1'b1;
    tick(3);
    bus.strobe = 1'b0;
    tick(10);
    chk("glitch_short_cnt", 128'(bus.beat_cnt), 0);
    bus.strobe = 1'b1;
    tick(6);
    bus.strobe = 1'b0;
    tick(10);
    chk("glitch_long_cnt", 128'(bus.beat_cnt), 1);
    close_frame;
    chk("glitch_close_err", 128'(bus.frame_err), 1);
    // strobe edge coincident with frame fall
    open_frame;
    beats(1, 16);
    bus.frame = 1'b0;
    bus.strobe = 1'b1;
    tick(12);
    bus.strobe = 1'b0;
    tick(8);
    chk("coinc_cnt", 128'(bus.beat_cnt), 16);
    chk("coinc_err", 128'(bus.frame_err), 1);
    chk("coinc_msg_held", 128'(bus.msg), 128'(held));
    // reset mid-frame, frame stays high
    open_frame;
    beats(0, 8);
    chk("pre_reset_cnt", 128'(bus.beat_cnt), 8);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_msg", 128'(bus.msg), 0);
    chk("mid_reset_flags", 128'({bus.msg_valid, bus.frame_err, bus.beat_cnt}), 0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    chk("post_reset_cnt", 128'(bus.beat_cnt), 0);
    beats(1, 17);
    chk("post_reset_full_cnt", 128'(bus.beat_cnt), 17);
    exp_q.push_back(build(1));
    close_frame;
    chk("post_reset_err", 128'(bus.frame_err), 0);
    chk("post_reset_msg", 128'(bus.msg), 128'(build(1)));
    tick(5);
    chk("scoreboard_drained", 128'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
